// File: rtl/mc_datapath.sv
// mc_datapath: multicycle ARM-style datapath (PC, IR, A/B/Data/ALUOut, 15-entry register file, split-enable flags).
// Optional B-path shifter enabled by defining MC_DP_SHIFT_EN.
module mc_datapath #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] PC_RESET = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Stall,
   input  logic             PCWrite,
   input  logic             AdrSrc,
   input  logic             IRWrite,
   input  logic [1:0]       RegSrc,
   input  logic             RegWrite,
   input  logic [1:0]       ImmSrc,
   input  logic             ALUSrcA,
   input  logic [1:0]       ALUSrcB,
   input  logic [2:0]       ALUControl,
   input  logic [1:0]       ResultSrc,
   input  logic [1:0]       FlagWrite,
   output logic [WIDTH-1:0] Adr,
   output logic [WIDTH-1:0] WriteData,
   input  logic [WIDTH-1:0] ReadData,
   output logic [31:0]      Instr,
   output logic [3:0]       ALUFlags,
   output logic [3:0]       Flags
);
   logic [WIDTH-1:0] r_pc, r_a, r_b, r_data, r_aluout;
   logic [31:0]      r_ir;
   logic [3:0]       r_flags;
   logic [WIDTH-1:0] r_rf [0:14];
   logic [3:0]       w_ra1, w_ra2;
   logic [WIDTH-1:0] w_pc4, w_rd1, w_rd2, w_ext, w_shb, w_srca, w_srcb, w_res, w_result;
   logic [WIDTH:0]   w_sum, w_diff;
   logic             w_c, w_v;

   assign w_ra1 = RegSrc[0] ? 4'd15 : r_ir[19:16];
   assign w_ra2 = RegSrc[1] ? r_ir[15:12] : r_ir[3:0];
   // R15 reads as PC+4: the PC already points one instruction ahead, giving architectural PC+8
   assign w_pc4 = r_pc + WIDTH'(4);
   assign w_rd1 = (w_ra1 == 4'd15) ? w_pc4 : r_rf[w_ra1];
   assign w_rd2 = (w_ra2 == 4'd15) ? w_pc4 : r_rf[w_ra2];

   assign w_ext = (ImmSrc == 2'b00) ? {{(WIDTH-8){1'b0}}, r_ir[7:0]} :
                  (ImmSrc == 2'b01) ? {{(WIDTH-12){1'b0}}, r_ir[11:0]} :
                  (ImmSrc == 2'b10) ? {{(WIDTH-26){r_ir[23]}}, r_ir[23:0], 2'b00} : '0;

`ifdef MC_DP_SHIFT_EN
   logic [4:0] w_shamt;
   assign w_shamt = r_ir[11:7];
   assign w_shb = (w_shamt == 5'd0)    ? r_b :
                  (r_ir[6:5] == 2'b00) ? r_b << w_shamt :
                  (r_ir[6:5] == 2'b01) ? r_b >> w_shamt :
                  (r_ir[6:5] == 2'b10) ? WIDTH'($signed(r_b) >>> w_shamt) :
                  (r_b >> w_shamt) | (r_b << (WIDTH - int'(w_shamt)));
`else
   assign w_shb = r_b;
`endif

   assign w_srca = ALUSrcA ? r_pc : r_a;
   assign w_srcb = (ALUSrcB == 2'b00) ? w_shb :
                   (ALUSrcB == 2'b01) ? w_ext :
                   (ALUSrcB == 2'b10) ? WIDTH'(4) : '0;

   // carry and not-borrow both come out of the extra top bit
   assign w_sum  = {1'b0, w_srca} + {1'b0, w_srcb};
   assign w_diff = {1'b0, w_srca} + {1'b0, ~w_srcb} + (WIDTH+1)'(1);
   assign w_res  = (ALUControl == 3'd0) ? w_sum[WIDTH-1:0] :
                   (ALUControl == 3'd1) ? w_diff[WIDTH-1:0] :
                   (ALUControl == 3'd2) ? (w_srca & w_srcb) :
                   (ALUControl == 3'd3) ? (w_srca | w_srcb) :
                   (ALUControl == 3'd4) ? (w_srca ^ w_srcb) :
                   (ALUControl == 3'd5) ? w_srcb : '0;
   assign w_c = (ALUControl == 3'd0) ? w_sum[WIDTH] :
                (ALUControl == 3'd1) ? w_diff[WIDTH] : 1'b0;
   assign w_v = (ALUControl == 3'd0) ? ((w_srca[WIDTH-1] == w_srcb[WIDTH-1]) && (w_res[WIDTH-1] != w_srca[WIDTH-1])) :
                (ALUControl == 3'd1) ? ((w_srca[WIDTH-1] != w_srcb[WIDTH-1]) && (w_res[WIDTH-1] != w_srca[WIDTH-1])) : 1'b0;
   assign ALUFlags = {w_res[WIDTH-1], w_res == '0, w_c, w_v};

   assign w_result  = (ResultSrc == 2'b01) ? r_data :
                      (ResultSrc == 2'b10) ? w_res : r_aluout;
   assign Adr       = AdrSrc ? w_result : r_pc;
   assign WriteData = r_b;
   assign Instr     = r_ir;
   assign Flags     = r_flags;

   // all architectural and step state; reset wins over stall, stall freezes everything
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc     <= PC_RESET;
         r_ir     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_data   <= '0;
         r_aluout <= '0;
         r_flags  <= '0;
         for (int i = 0; i < 15; i++) r_rf[i] <= '0;
      end else if (!Stall) begin
         r_a      <= w_rd1;
         r_b      <= w_rd2;
         r_data   <= ReadData;
         r_aluout <= w_res;
         if (IRWrite) r_ir <= ReadData[31:0];
         if (PCWrite) r_pc <= w_result;
         if (RegWrite && r_ir[15:12] != 4'd15) r_rf[r_ir[15:12]] <= w_result;
         if (FlagWrite[1]) r_flags[3:2] <= ALUFlags[3:2];
         if (FlagWrite[0]) r_flags[1:0] <= ALUFlags[1:0];
      end
   end
endmodule
